// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide unit state encoding and the
// R-type funct codes the control unit decodes for HI/LO operations.
// Optional macro MULT_DIV_UNSIGNED_EN adds the MULTU/DIVU funct codes.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MULT = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } md_state_t;

    localparam logic [5:0] MFHI_FUNCT = 6'h10;
    localparam logic [5:0] MFLO_FUNCT = 6'h12;
    localparam logic [5:0] MULT_FUNCT = 6'h18;
    localparam logic [5:0] DIV_FUNCT  = 6'h1A;
`ifdef MULT_DIV_UNSIGNED_EN
    localparam logic [5:0] MULTU_FUNCT = 6'h19;
    localparam logic [5:0] DIVU_FUNCT  = 6'h1B;
`endif

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift {rem,quo} left by one,
// subtract the divisor when it fits and record the quotient bit.
// Shared by the signed and unsigned divide paths.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // Trial subtraction; rem < divisor so the shifted value needs one extra bit
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, divisor});
        quo_next = {quo[WIDTH-2:0], fits};
        rem_next = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit for
// the multicycle MIPS datapath; one bit per cycle, results in hi/lo.
// Optional macro MULT_DIV_UNSIGNED_EN adds the is_unsigned input (MULTU/DIVU).
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mult_start,
    input  logic             div_start,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    // Two guard bits keep acc +/- multiplicand in range even for a
    // zero-extended unsigned multiplicand.
    localparam int ACC_W = WIDTH + 2;

    md_state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic             last_step;
    logic             op_unsigned;

    // Booth registers
    logic [ACC_W-1:0] acc, mcand, booth_sum, acc_next;
    logic [WIDTH-1:0] q, q_next;
    logic             q_m1, q_m1_next;
    logic             mult_fix;

    // Divide registers
    logic [WIDTH-1:0] rem, quo, divisor, rem_next, quo_next;
    logic             neg_quo, neg_rem;

    // Final results formed from the last iteration's next values
    logic [WIDTH-1:0] mult_hi, div_lo, div_hi;

`ifdef MULT_DIV_UNSIGNED_EN
    assign op_unsigned = is_unsigned;
`else
    assign op_unsigned = 1'b0;
`endif

    assign last_step = (cnt == CNT_W'(1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mult_start)           state_next = MULT;
                else if (div_start)       state_next = (b_in == '0) ? DONE : DIV;
            end
            MULT:    if (last_step) state_next = DONE;
            DIV:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Booth step: add/subtract per {q0,q_-1}, then arithmetic shift right
    always_comb begin
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b10:   booth_sum = acc - mcand;
            2'b01:   booth_sum = acc + mcand;
            default: booth_sum = acc;
        endcase
        acc_next  = {booth_sum[ACC_W-1], booth_sum[ACC_W-1:1]};
        q_next    = {booth_sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Result fix-up: Booth treats the multiplier as signed, so an unsigned
    // multiplier with its MSB set needs the multiplicand added into hi.
    always_comb begin
        mult_hi = acc_next[WIDTH-1:0] + (mult_fix ? mcand[WIDTH-1:0] : '0);
        div_lo  = neg_quo ? -quo_next : quo_next;
        div_hi  = neg_rem ? -rem_next : rem_next;
    end

    // Datapath registers; hi/lo are written on the final iteration edge so
    // they are already valid during the DONE cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
            mult_fix <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_start) begin
                        div_zero <= 1'b0;
                        acc      <= '0;
                        q        <= b_in;
                        q_m1     <= 1'b0;
                        mcand    <= op_unsigned ? {2'b00, a_in} : {{2{a_in[WIDTH-1]}}, a_in};
                        mult_fix <= op_unsigned & b_in[WIDTH-1];
                        cnt      <= CNT_W'(WIDTH);
                    end else if (div_start) begin
                        div_zero <= (b_in == '0);
                        rem      <= '0;
                        if (op_unsigned) begin
                            quo     <= a_in;
                            divisor <= b_in;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                        end else begin
                            quo     <= a_in[WIDTH-1] ? -a_in : a_in;
                            divisor <= b_in[WIDTH-1] ? -b_in : b_in;
                            neg_quo <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            neg_rem <= a_in[WIDTH-1];
                        end
                        cnt <= CNT_W'(WIDTH);
                    end
                end
                MULT: begin
                    acc  <= acc_next;
                    q    <= q_next;
                    q_m1 <= q_m1_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (last_step) begin
                        hi <= mult_hi;
                        lo <= q_next;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) begin
                        hi <= div_hi;
                        lo <= div_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             mult_start = 1'b0;
    logic             div_start = 1'b0;
    logic [WIDTH-1:0] hi, lo;
    logic             busy, done, div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .mult_start (mult_start),
        .div_start  (div_start),
`ifdef MULT_DIV_UNSIGNED_EN
        .is_unsigned(1'b0),
`endif
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Issue one operation, update the model, and check timing and results.
    // poke_at >= 0 pulses div_start that many cycles into the operation.
    task automatic run_op(input bit do_mult, input bit do_div,
                          input logic [31:0] a, input logic [31:0] b,
                          input int poke_at);
        longint      sa, sb, qv, rv;
        logic [63:0] p;
        int          lat, k, busy_cnt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (do_mult) begin
            p = 64'(sa * sb);
            exp_hi = p[63:32];
            exp_lo = p[31:0];
            exp_dz = 1'b0;
            lat    = WIDTH;
        end else if (b == 32'd0) begin
            exp_dz = 1'b1;
            lat    = 0;
        end else begin
            qv = sa / sb;
            rv = sa % sb;
            p = 64'(qv);
            exp_lo = p[31:0];
            p = 64'(rv);
            exp_hi = p[31:0];
            exp_dz = 1'b0;
            lat    = WIDTH;
        end

        @(negedge clock);
        a_in = a; b_in = b; mult_start = do_mult; div_start = do_div;
        @(posedge clock); #1;
        mult_start = 1'b0; div_start = 1'b0;
        a_in = $urandom; b_in = $urandom;

        k = 0; busy_cnt = 0;
        while (!done && k < 200) begin
            if (busy) busy_cnt++;
            if (k == poke_at) div_start = 1'b1;
            @(posedge clock); #1;
            div_start = 1'b0;
            k++;
        end
        if (busy) busy_cnt++;

        check("latency", 64'(k), 64'(lat));
        check("busy_cycles", 64'(busy_cnt), 64'(lat + 1));
        check("hi", 64'(hi), 64'(exp_hi));
        check("lo", 64'(lo), 64'(exp_lo));
        check("div_zero", 64'(div_zero), 64'(exp_dz));
        @(posedge clock); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin : main
        int extra_done;
        logic [31:0] ra, rb;
        int op;

        // Reset state
        #12;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        @(negedge clock); reset = 1'b1;

        // Directed cases
        run_op(1'b1, 1'b0, 32'd7, -32'sd3, -1);
        run_op(1'b0, 1'b1, -32'sd17, 32'd5, -1);
        run_op(1'b0, 1'b1, 32'h451, 32'h20, -1);          // hi=0x11, lo=0x22
        run_op(1'b0, 1'b1, 32'h1234, 32'd0, -1);          // divide by zero
        run_op(1'b1, 1'b0, 32'd3, 32'd4, -1);             // clears div_zero
        run_op(1'b1, 1'b1, 32'h7FFFFFFF, 32'd2, -1);      // multiply wins
        run_op(1'b1, 1'b0, 32'd1000, 32'd999, 5);         // div_start while busy

        extra_done = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) extra_done++;
        end
        check("no_extra_done", 64'(extra_done), 64'd0);
        check("hold_lo", 64'(lo), 64'(exp_lo));

        run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, -1); // overflow case

        // Reset during a divide
        @(negedge clock);
        a_in = -32'sd17; b_in = 32'd5; div_start = 1'b1;
        @(posedge clock); #1;
        div_start = 1'b0;
        repeat (9) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        @(negedge clock); reset = 1'b1;
        run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, -1);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'(int'($urandom_range(0, 20)) - 10);
                default: ;
            endcase
            if (op == 0)      run_op(1'b1, 1'b0, ra, rb, -1);
            else if (op == 1) run_op(1'b1, 1'b1, ra, rb, -1);
            else              run_op(1'b0, 1'b1, ra, rb, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
